// File: rtl/phase_accumulator.sv
// phase_accumulator
//   Programmable NCO front end. A frequency tuning word (inc) is accumulated
//   once per emitted sample, a phase offset is added, and the sum is
//   truncated to PHASE_DW bits. The result is streamed out on an AXI-stream
//   master with backpressure, ready for a DDS phase input.
//
//   Optional feature macro: PHASE_DITHER_EN
//     When defined, a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1)
//     steps once per emitted sample. Its low min(ACC_DW-PHASE_DW,16) bits are
//     added below the truncation point to spread truncation spurs.
//     When undefined, the output is a plain truncation and no LFSR exists.
//
// Parameters
//   ACC_DW    accumulator / tuning word / offset width
//   PHASE_DW  output phase width (must not exceed ACC_DW)
//
// Ports
//   clk                   clock
//   reset_n               synchronous active-low reset
//   s_axis_config_tdata   {phase_offset, phase_inc}, both unsigned
//   s_axis_config_tvalid  config word valid
//   s_axis_config_tready  config slot free (one-deep shadow buffer)
//   enable                run the accumulator
//   phase_sync            clear the accumulator to 0 (no sample that cycle)
//   m_axis_phase_tdata    unsigned phase, full scale = 2*pi
//   m_axis_phase_tvalid   phase valid
//   m_axis_phase_tready   downstream ready
//   wrap                  one-cycle pulse on accumulator carry-out
//
// Handshake semantics (both streams): a beat transfers on a rising clk edge
// where tvalid && tready. Once the master raises tvalid it keeps tvalid and
// tdata stable until that transfer happens; the master never waits on tready
// before asserting tvalid.

module phase_accumulator #(
  parameter int ACC_DW   = 32,
  parameter int PHASE_DW = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2*ACC_DW-1:0]   s_axis_config_tdata,
  input  logic                  s_axis_config_tvalid,
  output logic                  s_axis_config_tready,
  input  logic                  enable,
  input  logic                  phase_sync,
  output logic [PHASE_DW-1:0]   m_axis_phase_tdata,
  output logic                  m_axis_phase_tvalid,
  input  logic                  m_axis_phase_tready,
  output logic                  wrap
);

  logic [ACC_DW-1:0] acc;
  logic [ACC_DW-1:0] inc_act;
  logic [ACC_DW-1:0] off_act;
  logic [ACC_DW-1:0] inc_sh;
  logic [ACC_DW-1:0] off_sh;
  logic              pending;

  logic              adv;
  logic              apply_cfg;
  logic [ACC_DW:0]   acc_sum;     // carry bit on top
  logic [ACC_DW-1:0] phase_sum;
  logic [ACC_DW-1:0] phase_word;

  assign s_axis_config_tready = !pending;

  // A new sample is produced only when the output register is empty or is
  // being drained this cycle; phase_sync suppresses the sample.
  assign adv = enable && !phase_sync &&
               (!m_axis_phase_tvalid || m_axis_phase_tready);

  // Shadow config becomes active only at sample boundaries (or whenever the
  // accumulator is idle/resyncing), so a sample never mixes old and new words.
  assign apply_cfg = pending && (adv || phase_sync || !enable);

  assign acc_sum   = {1'b0, acc} + {1'b0, inc_act};
  assign phase_sum = acc + off_act;

`ifdef PHASE_DITHER_EN
  localparam int DITH_W = ((ACC_DW - PHASE_DW) < 16) ? (ACC_DW - PHASE_DW) : 16;

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  // Right-shifting Galois form; 0xB400 encodes taps 16,14,13,11.
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  generate
    if (DITH_W > 0) begin : g_dither
      assign phase_word = phase_sum + ACC_DW'(lfsr[DITH_W-1:0]);
    end else begin : g_no_dither
      assign phase_word = phase_sum;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else if (adv) begin
      lfsr <= lfsr_next;
    end
  end
`else
  assign phase_word = phase_sum;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc                 <= '0;
      inc_act             <= '0;
      off_act             <= '0;
      inc_sh              <= '0;
      off_sh              <= '0;
      pending             <= 1'b0;
      m_axis_phase_tdata  <= '0;
      m_axis_phase_tvalid <= 1'b0;
      wrap                <= 1'b0;
    end else begin
      // Config slot: accept only when empty, so accept and apply never
      // coincide.
      if (s_axis_config_tvalid && !pending) begin
        off_sh  <= s_axis_config_tdata[2*ACC_DW-1:ACC_DW];
        inc_sh  <= s_axis_config_tdata[ACC_DW-1:0];
        pending <= 1'b1;
      end else if (apply_cfg) begin
        off_act <= off_sh;
        inc_act <= inc_sh;
        pending <= 1'b0;
      end

      // Accumulator: sync wins over advance; otherwise frozen.
      if (phase_sync) begin
        acc <= '0;
      end else if (adv) begin
        acc <= acc_sum[ACC_DW-1:0];
      end

      // Output register: the beat is built from the pre-increment
      // accumulator and the offset that was active during this cycle.
      if (adv) begin
        m_axis_phase_tdata  <= PHASE_DW'(phase_word >> (ACC_DW - PHASE_DW));
        m_axis_phase_tvalid <= 1'b1;
        wrap                <= acc_sum[ACC_DW];
      end else begin
        wrap <= 1'b0;
        if (m_axis_phase_tvalid && m_axis_phase_tready) begin
          m_axis_phase_tvalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_accumulator.sv
// tb_phase_accumulator
//   Bench for phase_accumulator (ACC_DW=32, PHASE_DW=16, default build).
//   Expected beats come from an arithmetic model: beat k of a stream that
//   starts from acc=0 is ((k*inc + off) mod 2^32) >> 16, and its wrap flag
//   is whether k*inc mod 2^32 + inc overflows 32 bits.

module tb_phase_accumulator;

  logic        clk;
  logic        reset_n;
  logic [63:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic        enable;
  logic        phase_sync;
  logic [15:0] ph_tdata;
  logic        ph_tvalid;
  logic        ph_tready;
  logic        wrap;

  phase_accumulator #(
    .ACC_DW   (32),
    .PHASE_DW (16)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .s_axis_config_tdata  (cfg_tdata),
    .s_axis_config_tvalid (cfg_tvalid),
    .s_axis_config_tready (cfg_tready),
    .enable               (enable),
    .phase_sync           (phase_sync),
    .m_axis_phase_tdata   (ph_tdata),
    .m_axis_phase_tvalid  (ph_tvalid),
    .m_axis_phase_tready  (ph_tready),
    .wrap                 (wrap)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic        wrap_q[$];
  int          n_checks;
  int          n_pass;
  bit          mon_en;
  bit          prev_hold;
  bit          fresh;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: expected beats k = 0..n-1 of a stream starting at acc=0.
  task automatic push_model(input logic [31:0] off, input logic [31:0] inc,
                            input int n);
    longint unsigned a;
    longint unsigned two32;
    two32 = 64'h1_0000_0000;
    for (int k = 0; k < n; k++) begin
      a = (longint'(k) * longint'({32'd0, inc})) % two32;
      exp_q.push_back(16'(((a + {32'd0, off}) % two32) / 64'd65536));
      wrap_q.push_back((a + {32'd0, inc}) >= two32);
    end
  endtask

  task automatic push_beat(input logic [15:0] b, input logic w);
    exp_q.push_back(b);
    wrap_q.push_back(w);
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      fresh = ph_tvalid && !prev_hold;
      if (fresh) begin
        if (wrap_q.size() > 0) check_eq("wrap_beat", wrap, wrap_q[0]);
      end else begin
        check_eq("wrap_idle", wrap, 0);
      end
      if (ph_tvalid && exp_q.size() > 0) check_eq("beat", ph_tdata, exp_q[0]);
      if (ph_tvalid && ph_tready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(wrap_q.pop_front());
      end
      prev_hold = ph_tvalid && !ph_tready;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_q.delete();
    wrap_q.delete();
    reset_n    = 1'b0;
    enable     = 1'b0;
    phase_sync = 1'b0;
    cfg_tvalid = 1'b0;
    ph_tready  = 1'b1;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_tvalid", ph_tvalid, 0);
    check_eq("rst_tdata", ph_tdata, 0);
    check_eq("rst_wrap", wrap, 0);
    check_eq("rst_cfg_rdy", cfg_tready, 1);
    tick();
  endtask

  // Offer one config word; returns at the start of the cycle after transfer.
  task automatic send_cfg(input logic [31:0] off, input logic [31:0] inc);
    bit got;
    got        = 1'b0;
    cfg_tdata  = {off, inc};
    cfg_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = cfg_tready;
      tick();
      if (got) break;
    end
    cfg_tvalid = 1'b0;
    if (!got) check_eq("cfg_timeout", 0, 1);
  endtask

  // With enable low: slot is busy for exactly one cycle, then free again.
  task automatic apply_cfg(input logic [31:0] off, input logic [31:0] inc);
    send_cfg(off, inc);
    @(negedge clk);
    check_eq("cfg_busy", cfg_tready, 0);
    tick();
    @(negedge clk);
    check_eq("cfg_free", cfg_tready, 1);
    tick();
  endtask

  // Run until every expected beat has been consumed (bounded).
  task automatic drain(input bit rnd, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      if (rnd) begin
        ph_tready = ($urandom_range(0, 3) != 0);
        enable    = ($urandom_range(0, 4) != 0);
      end
      tick();
    end
    check_eq("drain_left", exp_q.size(), 0);
    enable    = 1'b0;
    ph_tready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks   = 0;
    n_pass     = 0;
    mon_en     = 1'b0;
    prev_hold  = 1'b0;
    reset_n    = 1'b0;
    cfg_tdata  = '0;
    cfg_tvalid = 1'b0;
    enable     = 1'b0;
    phase_sync = 1'b0;
    ph_tready  = 1'b1;
    tick();
    do_reset();
    mon_en = 1'b1;

    // Basic ramp and first-beat latency.
    apply_cfg(32'h0, 32'h0100_0000);
    push_model(32'h0, 32'h0100_0000, 10);
    enable = 1'b1;
    @(negedge clk);
    check_eq("lat_idle", ph_tvalid, 0);
    tick();
    @(negedge clk);
    check_eq("lat_first", ph_tvalid, 1);
    check_eq("lat_data", ph_tdata, 16'h0000);
    tick();
    drain(1'b0, 100);

    // Quarter-turn steps: wrap lands on the 0xC000 beat.
    do_reset();
    apply_cfg(32'h0, 32'h4000_0000);
    push_model(32'h0, 32'h4000_0000, 6);
    enable = 1'b1;
    drain(1'b0, 100);

    // Backpressure: hold 0x0200 for three cycles.
    do_reset();
    apply_cfg(32'h0, 32'h0100_0000);
    push_model(32'h0, 32'h0100_0000, 6);
    enable = 1'b1;
    tick();
    tick();
    tick();
    ph_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("hold_valid", ph_tvalid, 1);
      check_eq("hold_data", ph_tdata, 16'h0200);
      tick();
    end
    ph_tready = 1'b1;
    drain(1'b0, 100);

    // Mid-stream reconfiguration.
    do_reset();
    apply_cfg(32'h0, 32'h0100_0000);
    push_beat(16'h0000, 1'b0);
    push_beat(16'h0100, 1'b0);
    push_beat(16'h0200, 1'b0);
    push_beat(16'h0300, 1'b0);
    push_beat(16'h8400, 1'b0);
    push_beat(16'h8600, 1'b0);
    push_beat(16'h8800, 1'b0);
    enable = 1'b1;
    tick();
    tick();
    cfg_tdata  = {32'h8000_0000, 32'h0200_0000};
    cfg_tvalid = 1'b1;
    @(negedge clk);
    check_eq("run_cfg_rdy", cfg_tready, 1);
    tick();
    cfg_tvalid = 1'b0;
    @(negedge clk);
    check_eq("run_cfg_busy", cfg_tready, 0);
    tick();
    @(negedge clk);
    check_eq("run_cfg_free", cfg_tready, 1);
    drain(1'b0, 100);

    // phase_sync while 0x1500 is presented.
    do_reset();
    apply_cfg(32'h1000_0000, 32'h0100_0000);
    push_model(32'h1000_0000, 32'h0100_0000, 6);
    push_model(32'h1000_0000, 32'h0100_0000, 3);
    enable = 1'b1;
    repeat (6) tick();
    phase_sync = 1'b1;
    @(negedge clk);
    check_eq("sync_cur", ph_tdata, 16'h1500);
    tick();
    phase_sync = 1'b0;
    @(negedge clk);
    check_eq("sync_gap", ph_tvalid, 0);
    drain(1'b0, 100);

    // Reset mid-stream with a stalled beat and a pending config.
    do_reset();
    apply_cfg(32'h2000_0000, 32'h0100_0000);
    push_model(32'h2000_0000, 32'h0100_0000, 2);
    enable = 1'b1;
    tick();
    tick();
    ph_tready  = 1'b0;
    cfg_tdata  = {32'h5000_0000, 32'h0300_0000};
    cfg_tvalid = 1'b1;
    @(negedge clk);
    check_eq("stall_cfg_rdy", cfg_tready, 1);
    tick();
    cfg_tvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("stall_pending", cfg_tready, 0);
      check_eq("stall_data", ph_tdata, 16'h2100);
      tick();
    end
    do_reset();
    push_model(32'h0, 32'h0, 2);
    enable = 1'b1;
    drain(1'b0, 100);
    apply_cfg(32'h3000_0000, 32'h0100_0000);
    push_model(32'h3000_0000, 32'h0100_0000, 3);
    enable = 1'b1;
    drain(1'b0, 100);

    // Randomized streams with random enable and backpressure.
    for (int s = 0; s < 6; s++) begin
      logic [31:0] r_off;
      logic [31:0] r_inc;
      r_off = $urandom;
      r_inc = $urandom;
      if (s == 0) r_inc = 32'hFFFF_FFFF;
      do_reset();
      apply_cfg(r_off, r_inc);
      push_model(r_off, r_inc, 24);
      drain(1'b1, 800);
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
